// File: rtl/imem_pkg.sv
// Shared types, constants and address checks for the instruction memory
// access controller and its arbiter.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Legal means word aligned and no byte-address bits above the array size.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth_log2);
        logic [31:0] hi;
        hi = addr >> (depth_log2 + 2);
        return (addr[1:0] == 2'b00) && (hi == 32'h0);
    endfunction

endpackage

// File: rtl/imem_arb_prio.sv
// Fixed-priority fetch/load arbiter: the loader wins, except that a pending
// fetch is guaranteed a slot after MAX_LOAD_BURST consecutive load grants.
module imem_arb_prio #(
    parameter int MAX_LOAD_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_fetch_req,
    input  logic       i_load_req,
    output logic       o_grant_fetch,
    output logic       o_grant_load,
    output logic [3:0] o_burst_cnt
);

    logic [3:0] r_burst_cnt;
    logic       w_burst_full;

    assign w_burst_full = (r_burst_cnt == 4'(MAX_LOAD_BURST));

    // Grants are forced low while reset is held so every output reads zero.
    assign o_grant_load  = rst_n && i_load_req && !(i_fetch_req && w_burst_full);
    assign o_grant_fetch = rst_n && i_fetch_req && (!i_load_req || w_burst_full);
    assign o_burst_cnt   = r_burst_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= 4'd0;
        end else if (!i_fetch_req || o_grant_fetch) begin
            r_burst_cnt <= 4'd0;
        end else if (o_grant_load) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/imem_access_ctrl.sv
// Single-port instruction memory access controller: shares the memory port
// between IF-stage reads and loader writes, flagging illegal addresses.
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH_LOG2     = 8,
    parameter int MAX_LOAD_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_fetch_req,
    input  logic [31:0]           i_fetch_addr,
    output logic                  o_fetch_gnt,
    output logic                  o_fetch_valid,
    output logic [31:0]           o_fetch_rdata,
    output logic                  o_fetch_fault,
    input  logic                  i_load_req,
    input  logic [31:0]           i_load_addr,
    input  logic [31:0]           i_load_wdata,
    output logic                  o_load_gnt,
    output logic                  o_load_fault,
    output logic [DEPTH_LOG2-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata,
    output logic [1:0]            o_state
);

    // Handshake: a requester holds req (and its addr/wdata) steady until the
    // matching gnt is seen high at a rising edge; the access is taken then.

    state_t r_state;
    state_t w_state_nxt;

    logic       w_grant_fetch;
    logic       w_grant_load;
    logic [3:0] w_burst_cnt;
    logic       w_fetch_ok;
    logic       w_load_ok;
    logic       r_fetch_valid;
    logic       r_fetch_fault;

    imem_arb_prio #(
        .MAX_LOAD_BURST(MAX_LOAD_BURST)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fetch_req  (i_fetch_req),
        .i_load_req   (i_load_req),
        .o_grant_fetch(w_grant_fetch),
        .o_grant_load (w_grant_load),
        .o_burst_cnt  (w_burst_cnt)
    );

    assign w_fetch_ok = addr_ok(i_fetch_addr, DEPTH_LOG2);
    assign w_load_ok  = addr_ok(i_load_addr, DEPTH_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_fetch_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_valid <= w_grant_fetch;
            r_fetch_fault <= w_grant_fetch && !w_fetch_ok;
        end
    end

    // Every access occupies the port for one cycle, so arbitration runs in
    // every state and the next state only reflects which grant was issued.
    always_comb begin
        w_state_nxt  = ST_IDLE;
        o_fetch_gnt  = 1'b0;
        o_load_gnt   = 1'b0;
        o_load_fault = 1'b0;
        o_mem_addr   = '0;
        o_mem_we     = 1'b0;
        o_mem_wdata  = 32'h0;
        if (w_grant_fetch) begin
            w_state_nxt = ST_READ;
            o_fetch_gnt = 1'b1;
            if (w_fetch_ok) begin
                o_mem_addr = i_fetch_addr[DEPTH_LOG2+1:2];
            end
        end else if (w_grant_load) begin
            w_state_nxt  = ST_WRITE;
            o_load_gnt   = 1'b1;
            o_load_fault = !w_load_ok;
            if (w_load_ok) begin
                o_mem_we    = 1'b1;
                o_mem_addr  = i_load_addr[DEPTH_LOG2+1:2];
                o_mem_wdata = i_load_wdata;
            end
        end
    end

    // Memory read data arrives the cycle after the grant; faulted fetches
    // return a NOP instead of whatever word 0 holds.
    assign o_fetch_valid = r_fetch_valid;
    assign o_fetch_fault = r_fetch_fault;
    assign o_fetch_rdata = (r_fetch_valid && !r_fetch_fault) ? i_mem_rdata : NOP_WORD;
    assign o_state       = r_state;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a synchronous memory model.
module tb_imem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [31:0] fetch_rdata;
    logic        fetch_fault;
    logic        load_req;
    logic [31:0] load_addr;
    logic [31:0] load_wdata;
    logic        load_gnt;
    logic        load_fault;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  state;

    logic [31:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    imem_access_ctrl #(
        .DEPTH_LOG2    (8),
        .MAX_LOAD_BURST(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fetch_req  (fetch_req),
        .i_fetch_addr (fetch_addr),
        .o_fetch_gnt  (fetch_gnt),
        .o_fetch_valid(fetch_valid),
        .o_fetch_rdata(fetch_rdata),
        .o_fetch_fault(fetch_fault),
        .i_load_req   (load_req),
        .i_load_addr  (load_addr),
        .i_load_wdata (load_wdata),
        .o_load_gnt   (load_gnt),
        .o_load_fault (load_fault),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0]  pat;
        logic [31:0] exp_w [5];

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_1111;
        mem[2] = 32'h1509_FFFE;
        mem[3] = 32'h3333_3333;
        mem[4] = 32'h4444_4444;

        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        load_req   = 1'b0;
        load_addr  = 32'h0;
        load_wdata = 32'h0;

        // Reset state, with requests raised to confirm grants are held off.
        @(negedge clk);
        fetch_req = 1'b1;
        load_req  = 1'b1;
        #1;
        check_eq("rst_fetch_gnt", 32'(fetch_gnt), 32'h0);
        check_eq("rst_load_gnt", 32'(load_gnt), 32'h0);
        check_eq("rst_mem_we", 32'(mem_we), 32'h0);
        check_eq("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        check_eq("rst_fetch_rdata", fetch_rdata, 32'h0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_state", 32'(state), 32'h0);
        fetch_req = 1'b0;
        load_req  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        after_pos();

        // Single fetch of word 2.
        fetch_req  = 1'b1;
        fetch_addr = 32'h8;
        @(negedge clk);
        check_eq("f1_gnt", 32'(fetch_gnt), 32'h1);
        check_eq("f1_mem_addr", 32'(mem_addr), 32'h2);
        check_eq("f1_load_gnt", 32'(load_gnt), 32'h0);
        after_pos();
        fetch_req = 1'b0;
        @(negedge clk);
        check_eq("f1_valid", 32'(fetch_valid), 32'h1);
        check_eq("f1_rdata", fetch_rdata, 32'h1509_FFFE);
        check_eq("f1_fault", 32'(fetch_fault), 32'h0);
        check_eq("f1_state_read", 32'(state), 32'h1);

        // Load word 1, then read it back.
        after_pos();
        load_req   = 1'b1;
        load_addr  = 32'h4;
        load_wdata = 32'h2108_0001;
        @(negedge clk);
        check_eq("l1_gnt", 32'(load_gnt), 32'h1);
        check_eq("l1_we", 32'(mem_we), 32'h1);
        check_eq("l1_mem_addr", 32'(mem_addr), 32'h1);
        check_eq("l1_wdata", mem_wdata, 32'h2108_0001);
        check_eq("l1_fault", 32'(load_fault), 32'h0);
        check_eq("l1_fetch_gnt", 32'(fetch_gnt), 32'h0);
        after_pos();
        load_req   = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        @(negedge clk);
        check_eq("l1_state_write", 32'(state), 32'h2);
        check_eq("f2_gnt", 32'(fetch_gnt), 32'h1);
        check_eq("f2_mem_addr", 32'(mem_addr), 32'h1);
        after_pos();
        fetch_req = 1'b0;
        @(negedge clk);
        check_eq("f2_valid", 32'(fetch_valid), 32'h1);
        check_eq("f2_rdata", fetch_rdata, 32'h2108_0001);

        // Contention: expected L,L,L,L,F,L,L,L,L,F (bit i set = fetch in cycle i).
        after_pos();
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        load_req   = 1'b1;
        load_addr  = 32'h100;
        load_wdata = 32'hA5A5_0000;
        pat = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("burst_c%0d", i), {30'h0, fetch_gnt, load_gnt},
                     pat[i] ? 32'h2 : 32'h1);
            after_pos();
        end
        fetch_req = 1'b0;
        load_req  = 1'b0;

        // Illegal addresses: misaligned then out-of-range fetch, back to back.
        after_pos();
        fetch_req  = 1'b1;
        fetch_addr = 32'h6;
        @(negedge clk);
        check_eq("bad6_gnt", 32'(fetch_gnt), 32'h1);
        check_eq("bad6_mem_addr", 32'(mem_addr), 32'h0);
        after_pos();
        fetch_addr = 32'h400;
        @(negedge clk);
        check_eq("bad6_valid", 32'(fetch_valid), 32'h1);
        check_eq("bad6_fault", 32'(fetch_fault), 32'h1);
        check_eq("bad6_rdata", fetch_rdata, 32'h0);
        check_eq("bad400_gnt", 32'(fetch_gnt), 32'h1);
        check_eq("bad400_mem_addr", 32'(mem_addr), 32'h0);
        after_pos();
        fetch_req = 1'b0;
        @(negedge clk);
        check_eq("bad400_valid", 32'(fetch_valid), 32'h1);
        check_eq("bad400_fault", 32'(fetch_fault), 32'h1);
        check_eq("bad400_rdata", fetch_rdata, 32'h0);
        after_pos();
        load_req   = 1'b1;
        load_addr  = 32'h401;
        load_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("bad401_gnt", 32'(load_gnt), 32'h1);
        check_eq("bad401_fault", 32'(load_fault), 32'h1);
        check_eq("bad401_we", 32'(mem_we), 32'h0);
        after_pos();
        load_req = 1'b0;

        // Five back-to-back fetches of words 0..4.
        exp_w[0] = 32'h1111_1111;
        exp_w[1] = 32'h2108_0001;
        exp_w[2] = 32'h1509_FFFE;
        exp_w[3] = 32'h3333_3333;
        exp_w[4] = 32'h4444_4444;
        after_pos();
        for (int i = 0; i < 5; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'(i * 4);
            @(negedge clk);
            check_eq($sformatf("b2b_gnt%0d", i), 32'(fetch_gnt), 32'h1);
            check_eq($sformatf("b2b_addr%0d", i), 32'(mem_addr), 32'(i));
            if (i > 0) begin
                check_eq($sformatf("b2b_valid%0d", i - 1), 32'(fetch_valid), 32'h1);
                check_eq($sformatf("b2b_rdata%0d", i - 1), fetch_rdata, exp_w[i-1]);
            end
            after_pos();
        end
        fetch_req = 1'b0;
        @(negedge clk);
        check_eq("b2b_valid4", 32'(fetch_valid), 32'h1);
        check_eq("b2b_rdata4", fetch_rdata, exp_w[4]);

        // Asynchronous reset while a read is in flight.
        after_pos();
        fetch_req  = 1'b1;
        fetch_addr = 32'h8;
        @(posedge clk);
        #2;
        fetch_req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(fetch_valid), 32'h0);
        check_eq("arst_rdata", fetch_rdata, 32'h0);
        check_eq("arst_state", 32'(state), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_post_valid", 32'(fetch_valid), 32'h0);
        after_pos();
        fetch_req  = 1'b1;
        fetch_addr = 32'hC;
        @(negedge clk);
        check_eq("arst_f_gnt", 32'(fetch_gnt), 32'h1);
        check_eq("arst_f_addr", 32'(mem_addr), 32'h3);
        after_pos();
        fetch_req = 1'b0;
        @(negedge clk);
        check_eq("arst_f_valid", 32'(fetch_valid), 32'h1);
        check_eq("arst_f_rdata", fetch_rdata, 32'h3333_3333);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_access_ctrl.md
# imem_access_ctrl

Single-port access controller for the 256-word instruction memory. It shares one memory port between the pipeline IF stage (reads) and the program loader (word writes). Arbitration is fixed-priority with a starvation bound. Illegal addresses are flagged without touching memory. The block sits between the IF stage / loader and the instruction memory array, and sequences every access through a small FSM.

## Interface
- DEPTH_LOG2, 8, word-index width; memory holds 2^DEPTH_LOG2 32-bit words.
- MAX_LOAD_BURST, 4, maximum consecutive loader grants while a fetch is pending (1..15).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  IF stage requests a read; held until fetch_gnt.
- fetch_addr  in  32  byte address of the instruction.
- fetch_gnt  out  1  fetch accepted this cycle.
- fetch_valid  out  1  fetch_rdata/fetch_fault valid (one cycle after grant).
- fetch_rdata  out  32  instruction word.
- fetch_fault  out  1  address misaligned (addr[1:0]≠0) or beyond DEPTH (addr[31:DEPTH_LOG2+2]≠0).
- load_req  in  1  loader requests a write; held until load_gnt.
- load_addr  in  32  byte address to write.
- load_wdata  in  32  word to write.
- load_gnt  out  1  write accepted and issued this cycle.
- load_fault  out  1  pulses with load_gnt when the address is illegal (write suppressed).
- mem_addr  out  DEPTH_LOG2  word index (byte address [DEPTH_LOG2+1:2]).
- mem_we  out  1  write strobe.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid the cycle after mem_addr is presented with mem_we=0.

## Operation
- FSM states: IDLE, READ (read issued, data returning next cycle), WRITE (write issued this cycle).
- Arbitration each cycle the port is free (state IDLE, or READ/WRITE completing):
  - load_req wins over fetch_req, unless burst_cnt == MAX_LOAD_BURST and fetch_req is asserted; in that case fetch wins.
  - burst_cnt increments on each load grant while fetch_req is high.
  - burst_cnt clears on any fetch grant, and whenever fetch_req is low.
- Fetch grant: fetch_gnt=1; mem_addr=fetch_addr word index; go to READ. The next cycle, fetch_valid=1 and fetch_rdata=mem_rdata.
- Illegal fetch address:
  - Still granted and goes through READ, but mem_addr is forced to 0.
  - Next cycle: fetch_valid=1, fetch_fault=1, fetch_rdata=32'h0000_0000 (NOP).
- Load grant: load_gnt=1 and state goes to WRITE.
  - Legal address: mem_we=1, mem_addr/mem_wdata driven in the same cycle.
  - Illegal address: mem_we=0 and load_fault=1.
- Back-to-back: a new grant may be issued in the same cycle that fetch_valid is asserted. Sustained throughput is one access per cycle.
- Only one of fetch_gnt/load_gnt is ever high in a cycle. mem_we is never high without load_gnt.

## Timing
- Reset values: state IDLE, burst_cnt 0, all outputs 0 (fetch_rdata 0, mem_addr 0).
- Fetch latency: grant at cycle T, data at T+1. Load completes at its grant cycle T.
- Grant outputs are combinational from req and registered state. fetch_valid, fetch_rdata and fetch_fault are registered.
- Reset asserted mid-READ: fetch_valid stays 0. The requester must re-issue after reset.
- A request dropped before its grant is legal; it has no effect.
- Requests must not change addr or wdata while req=1 and gnt=0. Behaviour is not defined otherwise.

## Structure
- Shared package imem_pkg holds:
  - state enum (IDLE/READ/WRITE)
  - NOP_WORD = 32'h0
  - address-legality helper function addr_ok(addr, DEPTH_LOG2)
- Sub-module imem_arb_prio: combinational fixed-priority arbiter with the burst counter. It outputs grant_fetch and grant_load. The FSM and datapath stay in the top.

## Test plan
- Reset, then fetch_addr=0x8 with mem word 2 = 0x1509FFFE: fetch_gnt at T, fetch_valid with rdata 0x1509FFFE at T+1.
- load_req addr=0x4, wdata=0x21080001: load_gnt, mem_we=1, mem_addr=1 in the same cycle. A following fetch of 0x4 returns 0x21080001.
- fetch_req and load_req both held continuously, MAX_LOAD_BURST=4: grant pattern is L,L,L,L,F,L,L,L,L,F.
- fetch_addr=0x6 (misaligned) and fetch_addr=0x400 (out of range): fetch_valid with fetch_fault=1, rdata 0. load_addr=0x401: load_gnt with load_fault=1 and mem_we=0.
- 5 back-to-back fetches at 0,4,8,C,10: one grant per cycle, 5 consecutive fetch_valid pulses with the matching words.
- rst_n asserted asynchronously mid-clock while in READ: outputs zero immediately, no fetch_valid after release, next fetch works normally.
